// File: rtl/jtag_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtag_mem_pkg
// Purpose  : Shared types and defaults for the JTAG memory-access sequencer
// Revision : 1.0 - initial release
// ============================================================================
package jtag_mem_pkg;

   localparam int DW_DEF     = 64;
   localparam int CLR_AW_DEF = 14;
   localparam int STEP       = DW_DEF / 8;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_REQ   = 2'd2,
      ST_RWAIT = 2'd3
   } state_t;

   // Byte distance between consecutive words for a given data width
   function automatic logic [31:0] step_of(input int dw);
      return 32'(dw / 8);
   endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_mem_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : jtag_mem_seq_if
// Purpose  : Request/grant memory bus with a separate read-valid return path
// Revision : 1.0 - initial release
// ============================================================================
interface jtag_mem_seq_if
   import jtag_mem_pkg::*;
#(
   parameter int DW = DW_DEF
) ();

   logic          req;
   logic          we;
   logic [31:0]   addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );

endinterface
`default_nettype wire

// File: rtl/jtag_mem_seq.sv
`default_nettype none
// ============================================================================
// Module   : jtag_mem_seq
// Purpose  : Turns JTAG address/data register updates into single memory
//            accesses with optional auto-increment; zero-fills the bottom of
//            memory after every reset.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_mem_seq
   import jtag_mem_pkg::*;
#(
   parameter int DW     = DW_DEF,
   parameter int CLR_AW = CLR_AW_DEF
) (
   input  wire logic          tck,
   input  wire logic          reset,
   input  wire logic [31:0]   cfg_addr,
   input  wire logic          cfg_wr,
   input  wire logic          cfg_inc,
   input  wire logic          cfg_load,
   input  wire logic          data_upd,
   input  wire logic [DW-1:0] data_wr,
   output logic      [DW-1:0] data_rd,
   output logic               busy,
   output logic               clr_done,
   output logic               ovr,
   jtag_mem_seq_if.master     mem
);

   localparam logic [31:0] STEP_B = step_of(DW);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CLR_AW-1:0] r_clr_k;
   logic          r_clr_arm;   // keeps the bus quiet during the reset edge itself
   logic [31:0]   r_ptr;
   logic          r_mode;
   logic          r_inc;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_data_rd;
   logic          r_ovr;
   logic          r_clr_done;

   logic          w_in_clear;
   logic          w_clr_hs;
   logic          w_clr_last;
   logic          w_wr_done;
   logic          w_rd_done;
   logic          w_busy_hit;
   logic [31:0]   w_clr_addr;

   assign w_in_clear = (r_state == ST_CLEAR);
   assign w_clr_hs   = w_in_clear & r_clr_arm & mem.gnt;
   assign w_clr_last = &r_clr_k;
   assign w_wr_done  = (r_state == ST_REQ) & mem.gnt & r_mode;
   assign w_rd_done  = (r_state == ST_RWAIT) & mem.rvalid;
   assign w_busy_hit = (r_state != ST_IDLE) & (cfg_load | data_upd);
   assign w_clr_addr = 32'(r_clr_k) * STEP_B;

   // Bus drive: clear counter and pointer share the address mux
   assign mem.req   = (r_state == ST_REQ) | (w_in_clear & r_clr_arm);
   assign mem.we    = ((r_state == ST_REQ) & r_mode) | (w_in_clear & r_clr_arm);
   assign mem.addr  = w_in_clear ? w_clr_addr : r_ptr;
   assign mem.wdata = w_in_clear ? '0 : r_wdata;

   assign data_rd  = r_data_rd;
   assign busy     = (r_state != ST_IDLE);
   assign clr_done = r_clr_done;
   assign ovr      = r_ovr;

   // State register
   always_ff @(posedge tck) begin
      if (reset) r_state <= ST_CLEAR;
      else       r_state <= w_state_nxt;
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_CLEAR: if (w_clr_hs && w_clr_last) w_state_nxt = ST_IDLE;
         ST_IDLE:  if (data_upd)               w_state_nxt = ST_REQ;
         ST_REQ:   if (mem.gnt)                w_state_nxt = r_mode ? ST_IDLE : ST_RWAIT;
         ST_RWAIT: if (mem.rvalid)             w_state_nxt = ST_IDLE;
         default:                              w_state_nxt = ST_CLEAR;
      endcase
   end

   // Datapath: clear counter, pointer/mode, captured data and status flags
   always_ff @(posedge tck) begin
      if (reset) begin
         r_clr_k    <= '0;
         r_clr_arm  <= 1'b0;
         r_ptr      <= '0;
         r_mode     <= 1'b0;
         r_inc      <= 1'b0;
         r_wdata    <= '0;
         r_data_rd  <= '0;
         r_ovr      <= 1'b0;
         r_clr_done <= 1'b0;
      end else begin
         r_clr_arm <= 1'b1;
         if (w_clr_hs) r_clr_k <= r_clr_k + 1'b1;
         if (w_clr_hs && w_clr_last) r_clr_done <= 1'b1;
         if (w_busy_hit) r_ovr <= 1'b1;
         if (r_state == ST_IDLE) begin
            // A load in the same cycle as an update wins, so the access uses it
            if (cfg_load) begin
               r_ptr  <= cfg_addr;
               r_mode <= cfg_wr;
               r_inc  <= cfg_inc;
               r_ovr  <= 1'b0;
            end
            if (data_upd) r_wdata <= data_wr;
         end
         if ((w_wr_done || w_rd_done) && r_inc) r_ptr <= r_ptr + STEP_B;
         if (w_rd_done) r_data_rd <= mem.rdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jtag_mem_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_mem_seq
// Purpose  : Self-checking bench for jtag_mem_seq with a transaction model
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_mem_seq;

   localparam int DW      = 64;
   localparam int CLR_AW  = 2;
   localparam int STEP_TB = 8;

   logic          tck = 1'b0;
   logic          reset;
   logic [31:0]   cfg_addr;
   logic          cfg_wr, cfg_inc, cfg_load, data_upd;
   logic [DW-1:0] data_wr;
   logic [DW-1:0] data_rd;
   logic          busy, clr_done, ovr;

   jtag_mem_seq_if #(.DW(DW)) mem ();

   jtag_mem_seq #(.DW(DW), .CLR_AW(CLR_AW)) dut (
      .tck      (tck),
      .reset    (reset),
      .cfg_addr (cfg_addr),
      .cfg_wr   (cfg_wr),
      .cfg_inc  (cfg_inc),
      .cfg_load (cfg_load),
      .data_upd (data_upd),
      .data_wr  (data_wr),
      .data_rd  (data_rd),
      .busy     (busy),
      .clr_done (clr_done),
      .ovr      (ovr),
      .mem      (mem)
   );

   always #5 tck = ~tck;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: architectural pointer, mode and status
   logic [31:0]   m_ptr;
   logic          m_wr, m_inc, m_ovr;
   logic [DW-1:0] m_rd;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   task automatic model_reset();
      m_ptr = '0; m_wr = 1'b0; m_inc = 1'b0; m_ovr = 1'b0; m_rd = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      model_reset();
      chk("rst_busy",     64'(busy),     64'd1);
      chk("rst_req",      64'(mem.req),  64'd0);
      chk("rst_we",       64'(mem.we),   64'd0);
      chk("rst_clr_done", 64'(clr_done), 64'd0);
      chk("rst_ovr",      64'(ovr),      64'd0);
      chk("rst_data_rd",  64'(data_rd),  64'd0);
      reset = 1'b0;
   endtask

   // Serve the zero-fill; gnt either tied high or random, optional busy poke
   task automatic run_clear(input bit gnt_tied, input bit poke);
      int k   = 0;
      int cyc = 0;
      while (k < (1 << CLR_AW) && cyc < 200) begin
         if (mem.req) begin
            chk("clr_we",    64'(mem.we),    64'd1);
            chk("clr_addr",  64'(mem.addr),  64'(k * STEP_TB));
            chk("clr_wdata", 64'(mem.wdata), 64'd0);
         end
         chk("clr_busy", 64'(busy), 64'd1);
         mem.gnt = gnt_tied ? 1'b1 : 1'($urandom_range(0, 1));
         if (poke && cyc == 1) begin
            cfg_addr = 32'hDEAD_0000;
            cfg_load = 1'b1;
            m_ovr    = 1'b1;
         end
         if (mem.req && mem.gnt) k++;
         tick();
         mem.gnt  = 1'b0;
         cfg_load = 1'b0;
         cyc++;
      end
      if (cyc >= 200) chk("clr_timeout", 64'd0, 64'd1);
      chk("clr_end_busy", 64'(busy),     64'd0);
      chk("clr_end_done", 64'(clr_done), 64'd1);
      chk("clr_end_req",  64'(mem.req),  64'd0);
      chk("clr_end_ovr",  64'(ovr),      64'(m_ovr));
   endtask

   task automatic load(input logic [31:0] a, input bit wr, input bit inc);
      cfg_addr = a; cfg_wr = wr; cfg_inc = inc; cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      m_ptr = a; m_wr = wr; m_inc = inc; m_ovr = 1'b0;
      chk("load_ovr",  64'(ovr),  64'd0);
      chk("load_busy", 64'(busy), 64'd0);
   endtask

   // One access: grant after gdly stall cycles, read data lat cycles after grant
   task automatic access(input logic [DW-1:0] d, input int gdly, input int lat,
                         input bit also_load, input logic [31:0] a, input bit wr,
                         input bit inc, input bit poke);
      logic [31:0]   exp_addr;
      logic [DW-1:0] rdv;
      if (also_load) begin
         cfg_addr = a; cfg_wr = wr; cfg_inc = inc; cfg_load = 1'b1;
         m_ptr = a; m_wr = wr; m_inc = inc; m_ovr = 1'b0;
      end
      data_wr  = d;
      data_upd = 1'b1;
      tick();
      cfg_load = 1'b0;
      data_upd = 1'b0;
      data_wr  = {$urandom, $urandom};
      exp_addr = m_ptr;
      for (int i = 0; i <= gdly; i++) begin
         chk("acc_req",  64'(mem.req),  64'd1);
         chk("acc_addr", 64'(mem.addr), 64'(exp_addr));
         chk("acc_we",   64'(mem.we),   64'(m_wr));
         if (m_wr) chk("acc_wdata", 64'(mem.wdata), 64'(d));
         chk("acc_busy", 64'(busy), 64'd1);
         mem.gnt = (i == gdly);
         if (poke && i == 0 && gdly > 0) begin
            data_upd = 1'b1;
            m_ovr    = 1'b1;
         end
         tick();
         mem.gnt  = 1'b0;
         data_upd = 1'b0;
      end
      if (!m_wr) begin
         for (int i = 0; i < lat - 1; i++) begin
            chk("rwait_req",  64'(mem.req), 64'd0);
            chk("rwait_busy", 64'(busy),    64'd1);
            tick();
         end
         rdv        = {$urandom, $urandom};
         mem.rdata  = rdv;
         mem.rvalid = 1'b1;
         tick();
         mem.rvalid = 1'b0;
         m_rd = rdv;
      end
      if (m_inc) m_ptr = m_ptr + 32'(STEP_TB);
      chk("done_busy", 64'(busy),    64'd0);
      chk("done_req",  64'(mem.req), 64'd0);
      chk("data_rd",   64'(data_rd), 64'(m_rd));
      chk("done_ovr",  64'(ovr),     64'(m_ovr));
   endtask

   task automatic stale_rvalid();
      mem.rdata  = {$urandom, $urandom};
      mem.rvalid = 1'b1;
      tick();
      mem.rvalid = 1'b0;
      chk("stale_data_rd", 64'(data_rd), 64'(m_rd));
      chk("stale_busy",    64'(busy),    64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cfg_addr = '0; cfg_wr = 1'b0; cfg_inc = 1'b0;
      cfg_load = 1'b0; data_upd = 1'b0; data_wr = '0;
      mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = '0;

      // Zero-fill with grant tied high
      do_reset();
      run_clear(1'b1, 1'b0);

      // Incrementing write burst
      load(32'h0000_1000, 1'b1, 1'b1);
      access(64'hAAAA_0000_0000_000A, 0, 1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      access(64'hBBBB_0000_0000_000B, 0, 1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      access(64'hCCCC_0000_0000_000C, 0, 1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Read with three-cycle latency, then a follow-up showing the advance
      load(32'h0000_2000, 1'b0, 1'b1);
      access('0, 1, 3, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      access('0, 0, 2, 1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Overrun during a stalled request, single request, cleared by load
      load(32'h0000_3000, 1'b1, 1'b0);
      access(64'h1234_5678_9ABC_DEF0, 5, 1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("ovr_single_req", 64'(mem.req), 64'd0);
      chk("ovr_sticky",     64'(ovr),     64'd1);
      load(32'h0000_3100, 1'b1, 1'b0);

      // Pointer wrap
      load(32'hFFFF_FFF8, 1'b1, 1'b1);
      access(64'h1, 0, 1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      access(64'h2, 0, 1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("wrap_ptr_model", 64'(m_ptr), 64'h8);

      // Load and update in the same cycle
      load(32'h0000_5000, 1'b0, 1'b0);
      access(64'h77, 1, 1, 1'b1, 32'h0000_6000, 1'b1, 1'b1, 1'b0);
      stale_rvalid();

      // Reset while a read is outstanding, followed by a stale rvalid
      load(32'h0000_4000, 1'b0, 1'b0);
      data_upd = 1'b1;
      tick();
      data_upd = 1'b0;
      mem.gnt  = 1'b1;
      tick();
      mem.gnt  = 1'b0;
      chk("mid_rwait_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      chk("mid_rst_req", 64'(mem.req), 64'd0);
      chk("mid_rst_we",  64'(mem.we),  64'd0);
      mem.rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
      mem.rvalid = 1'b1;
      tick();
      mem.rvalid = 1'b0;
      chk("mid_rst_data_rd",  64'(data_rd),  64'd0);
      chk("mid_rst_busy",     64'(busy),     64'd1);
      chk("mid_rst_clr_done", 64'(clr_done), 64'd0);
      run_clear(1'b0, 1'b1);
      load(32'h0000_0100, 1'b1, 1'b1);

      // Randomized traffic
      for (int it = 0; it < 40; it++) begin
         logic [31:0] a;
         int n;
         a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFF8);
         load(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         n = $urandom_range(1, 3);
         for (int j = 0; j < n; j++) begin
            if ($urandom_range(0, 4) == 0)
               access({$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(1, 4),
                      1'b1, $urandom & 32'hFFFF_FFF8, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b0);
            else
               access({$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(1, 4),
                      1'b0, '0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) stale_rvalid();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jtag_mem_seq.md
JTAG_MEM_SEQ -- requirements
Module: jtag_mem_seq

Interface
REQ-001 SHALL have parameter DW, default 64, meaning memory data width in bits; the byte step per word is STEP = DW/8.
REQ-002 SHALL have parameter CLR_AW, default 14, meaning that 2^CLR_AW words are cleared after reset.
REQ-003 TCK  in  1  the single clock; all logic is on the posedge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 CFG_ADDR  in  32  byte start address from the JTAG address register.
REQ-006 CFG_WR  in  1  access mode: 1 = write, 0 = read.
REQ-007 CFG_INC  in  1  when 1, the pointer advances by STEP after each completed access.
REQ-008 CFG_LOAD  in  1  one-cycle pulse from the address-register UPDATE.
REQ-009 DATA_UPD  in  1  one-cycle pulse from the data-register UPDATE; triggers one access.
REQ-010 DATA_WR  in  DW  write data.
REQ-011 DATA_RD  out  DW  last read data.
REQ-012 MEM_REQ, MEM_WE  out  1  request and write-enable.
REQ-013 MEM_ADDR  out  32  access address.
REQ-014 MEM_WDATA  out  DW  data for a write access.
REQ-015 MEM_GNT  in  1  grant for MEM_REQ.
REQ-016 MEM_RVALID  in  1  read-data-valid strobe.
REQ-017 MEM_RDATA  in  DW  read data, sampled on MEM_RVALID.
REQ-018 BUSY, CLR_DONE, OVR  out  1  busy (state != IDLE), clear complete, sticky overrun.

Function
REQ-019 The state machine SHALL have four states: CLEAR, IDLE, REQ, RWAIT.
REQ-020 CLEAR: SHALL issue zero writes to addresses k*STEP for k = 0..2^CLR_AW-1, one per handshake, advancing k on each MEM_GNT.
REQ-021 CLEAR: after the MEM_GNT for the last k, SHALL move to IDLE and set CLR_DONE on the next cycle; CLR_DONE then stays 1 until RESET.
REQ-022 IDLE, CFG_LOAD=1: SHALL load PTR with CFG_ADDR and latch MODE from CFG_WR and INC from CFG_INC.
REQ-023 IDLE, DATA_UPD=1: SHALL go to REQ on the next cycle with MEM_ADDR=PTR and MEM_WE=MODE; for a write, MEM_WDATA is DATA_WR captured at the pulse.
REQ-024 CFG_LOAD and DATA_UPD in the same IDLE cycle: the access SHALL use the newly loaded PTR and mode.
REQ-025 REQ: MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA SHALL be held stable until MEM_GNT=1.
REQ-026 REQ, on MEM_GNT: a write SHALL go to IDLE; a read SHALL go to RWAIT.
REQ-027 RWAIT, on MEM_RVALID: SHALL latch MEM_RDATA into DATA_RD and go to IDLE; DATA_RD SHALL otherwise hold its value.
REQ-028 Pointer advance: PTR SHALL advance by STEP on completion (write: MEM_GNT; read: MEM_RVALID) when INC=1.
REQ-029 PTR SHALL wrap modulo 2^32.
REQ-030 A CFG_LOAD or DATA_UPD pulse while BUSY=1 (including CLEAR) SHALL be ignored and SHALL set OVR.
REQ-031 OVR SHALL clear on RESET or on a CFG_LOAD accepted in IDLE.
REQ-032 MEM_RVALID arriving outside RWAIT SHALL be ignored.
REQ-033 MEM_REQ SHALL be 0 in IDLE and RWAIT.
REQ-034 At most one access SHALL be outstanding at any time.

Reset
REQ-035 RESET=1 at any posedge, including mid-access, SHALL force state CLEAR with k=0.
REQ-036 RESET SHALL set PTR, MODE, INC, DATA_RD, OVR and CLR_DONE to 0, and drop MEM_REQ and MEM_WE to 0 in the same edge.
REQ-037 RESET SHALL NOT wait for an outstanding grant or read completion.

Structure
REQ-038 Package jtag_mem_pkg SHALL hold the state enum, the DW and CLR_AW defaults, and STEP.
REQ-039 The block SHALL be a single module with no sub-module; the clear counter and PTR share the MEM_ADDR mux.

Verification
REQ-040 Clear: RESET, CLR_AW=2, MEM_GNT tied 1 -> writes of 0 to 0x0, 0x8, 0x10, 0x18, then CLR_DONE=1 and BUSY=0.
REQ-041 Write burst: CFG_ADDR=0x1000, CFG_WR=1, CFG_INC=1, three DATA_UPD pulses with data A, B, C -> writes to 0x1000, 0x1008, 0x1010.
REQ-042 Read with 3-cycle RVALID latency: CFG_ADDR=0x2000, CFG_WR=0 -> DATA_RD=MEM_RDATA, PTR=0x2008, BUSY low after RVALID.
REQ-043 Overrun: DATA_UPD during REQ with MEM_GNT held 0 for 5 cycles -> OVR=1, only one request issued; OVR returns to 0 after the next CFG_LOAD.
REQ-044 Wrap: CFG_ADDR=0xFFFFFFF8, CFG_INC=1, two writes -> addresses 0xFFFFFFF8 then 0x0.
REQ-045 Reset mid-read: RESET in RWAIT, then a stale RVALID -> DATA_RD=0 and state CLEAR.
